// File: rtl/y_compact_pkg.sv
// Shared constants, FSM state type and the XOR fold used by the y-bus signature compactor.
// Consumed by y_compact_misr_step, y_signature_compactor and any golden-model checker.
package y_compact_pkg;

   localparam int Y_W   = 245;
   localparam int SIG_W = 32;
   localparam int CNT_W = 16;

   localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
   localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

   // y is zero-padded up to a whole number of signature words before folding
   localparam int FOLD_N = (Y_W + SIG_W - 1) / SIG_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [SIG_W-1:0] fold(input logic [Y_W-1:0] y);
      logic [FOLD_N*SIG_W-1:0] ypad;
      logic [SIG_W-1:0]        acc;
      ypad           = '0;
      ypad[Y_W-1:0]  = y;
      acc            = '0;
      for (int i = 0; i < FOLD_N; i++) begin
         acc = acc ^ ypad[i*SIG_W +: SIG_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/y_compact_misr_step.sv
// One combinational MISR step: shifts the signature, applies POLY feedback and folds in y.
// Kept separate so a golden-model checker can instance the exact same step.
module y_compact_misr_step
   import y_compact_pkg::*;
(
   input  logic [SIG_W-1:0] sig,
   input  logic [Y_W-1:0]   y,
   output logic [SIG_W-1:0] sig_n
);

   assign sig_n = {sig[SIG_W-2:0], 1'b0}
                ^ (sig[SIG_W-1] ? POLY : '0)
                ^ fold(y);

endmodule

// File: rtl/y_signature_compactor.sv
// Compacts a run of y samples into one 32-bit MISR signature with a valid/ready result handshake.
// Optional golden-signature compare ports are enabled by defining Y_COMPACT_CMP_EN.
module y_signature_compactor
   import y_compact_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [Y_W-1:0]   y,
   input  logic             y_valid,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   output logic             busy,
   output logic [SIG_W-1:0] sig,
   output logic             sig_valid,
`ifdef Y_COMPACT_CMP_EN
   input  logic [SIG_W-1:0] golden_sig,
   output logic             pass,
   output logic             fail,
`endif
   input  logic             sig_ready
);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic [CNT_W-1:0] n_q;
   logic [SIG_W-1:0] sig_n;

   y_compact_misr_step u_step (
      .sig   (sig),
      .y     (y),
      .sig_n (sig_n)
   );

   assign count_inc = count + CNT_W'(1);

   // A sample lands in sig on the same edge that accepts it; the last accepted sample also ends the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sig       <= SEED;
         count     <= '0;
         n_q       <= '0;
         busy      <= 1'b0;
         sig_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sig   <= SEED;
                  count <= '0;
                  n_q   <= num_samples;
                  if (num_samples == '0) begin
                     state     <= DONE;
                     sig_valid <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (y_valid) begin
                  sig   <= sig_n;
                  count <= count_inc;
                  if (count_inc == n_q) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     sig_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (sig_ready) begin
                  state     <= IDLE;
                  sig_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               sig_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef Y_COMPACT_CMP_EN
   assign pass = (state == DONE) && (sig == golden_sig);
   assign fail = (state == DONE) && (sig != golden_sig);
`endif

endmodule

// File: tb/tb_y_signature_compactor.sv
// Directed-plus-random bench for y_signature_compactor against a word-level MISR reference model.
// Also covers the golden-compare ports when Y_COMPACT_CMP_EN is defined.
module tb_y_signature_compactor;

   localparam logic [31:0] REF_POLY = 32'h04C11DB7;
   localparam logic [31:0] REF_SEED = 32'hFFFFFFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic [244:0] y;
   logic         y_valid;
   logic         start;
   logic [15:0]  num_samples;
   logic         busy;
   logic [31:0]  sig;
   logic         sig_valid;
   logic         sig_ready;
`ifdef Y_COMPACT_CMP_EN
   logic [31:0]  golden_sig;
   logic         pass;
   logic         fail;
`endif

   int           vectors = 0;
   int           miscompares = 0;
   logic [31:0]  modelSig;

   always #5 clk = ~clk;

   y_signature_compactor dut (
      .clk         (clk),
      .rst         (rst),
      .y           (y),
      .y_valid     (y_valid),
      .start       (start),
      .num_samples (num_samples),
      .busy        (busy),
      .sig         (sig),
      .sig_valid   (sig_valid),
`ifdef Y_COMPACT_CMP_EN
      .golden_sig  (golden_sig),
      .pass        (pass),
      .fail        (fail),
`endif
      .sig_ready   (sig_ready)
   );

   // Reference: XOR of the eight 32-bit words of the zero-extended sample, then a CRC-style shift.
   function automatic logic [31:0] refFold(input logic [244:0] v);
      logic [255:0] p;
      logic [31:0]  r;
      p = {11'b0, v};
      r = 32'h0;
      for (int i = 0; i < 8; i++) begin
         r = r ^ 32'(p >> (32 * i));
      end
      return r;
   endfunction

   function automatic logic [31:0] refStep(input logic [31:0] s, input logic [244:0] v);
      logic [31:0] shifted;
      shifted = 32'((64'(s) * 2) % 64'h1_0000_0000);
      if (s >= 32'h8000_0000) shifted = shifted ^ REF_POLY;
      return shifted ^ refFold(v);
   endfunction

   function automatic logic [244:0] randY();
      logic [255:0] t;
      for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
      return t[244:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, let one rising edge pass, then settle 1 time unit past it.
   task automatic applyStimulus(input logic st, input logic [15:0] n, input logic [244:0] v,
                                input logic vv, input logic rdy);
      start       = st;
      num_samples = n;
      y           = v;
      y_valid     = vv;
      sig_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic handshakeAndGap(input string tag);
      applyStimulus(1'b1, 16'd1, 245'h0, 1'b1, 1'b1);
      checkOutput({tag, "_hs_valid"}, 32'(sig_valid), 32'h0);
      checkOutput({tag, "_hs_sig"}, sig, modelSig);
      applyStimulus(1'b0, 16'd0, 245'h0, 1'b0, 1'b0);
      checkOutput({tag, "_dropped_start_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_dropped_start_valid"}, 32'(sig_valid), 32'h0);
   endtask

   task automatic runSingle(input string tag, input logic [244:0] v, input logic [31:0] spec);
      applyStimulus(1'b1, 16'd1, 245'h0, 1'b0, 1'b0);
      modelSig = REF_SEED;
      checkOutput({tag, "_busy_run"}, 32'(busy), 32'h1);
      applyStimulus(1'b0, 16'd7, v, 1'b1, 1'b0);
      modelSig = refStep(modelSig, v);
      checkOutput({tag, "_sig_model"}, sig, modelSig);
      checkOutput({tag, "_sig_spec"}, sig, spec);
      checkOutput({tag, "_valid"}, 32'(sig_valid), 32'h1);
      checkOutput({tag, "_busy_done"}, 32'(busy), 32'h0);
   endtask

   task automatic runRandom(input logic [15:0] n, input int holdCycles);
      int accepted = 0;
      int cycles = 0;
      logic vv;
      logic [244:0] v;
      applyStimulus(1'b1, n, randY(), 1'($urandom_range(0, 1)), 1'b0);
      modelSig = REF_SEED;
      checkOutput("rnd_start_busy", 32'(busy), 32'h1);
      checkOutput("rnd_start_sig", sig, REF_SEED);
      while (accepted < int'(n) && cycles < 200) begin
         vv = 1'($urandom_range(0, 1));
         v  = randY();
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), v, vv, 1'($urandom_range(0, 1)));
         if (vv) begin
            modelSig = refStep(modelSig, v);
            accepted++;
         end
         cycles++;
         checkOutput("rnd_run_sig", sig, modelSig);
         checkOutput("rnd_run_busy", 32'(busy), (accepted < int'(n)) ? 32'h1 : 32'h0);
      end
      if (accepted < int'(n)) checkOutput("rnd_cycle_budget", 32'(accepted), 32'(n));
      checkOutput("rnd_done_valid", 32'(sig_valid), 32'h1);
      for (int k = 0; k < holdCycles; k++) begin
         applyStimulus(1'b1, 16'd2, randY(), 1'b1, 1'b0);
         checkOutput("rnd_hold_sig", sig, modelSig);
         checkOutput("rnd_hold_valid", 32'(sig_valid), 32'h1);
         checkOutput("rnd_hold_busy", 32'(busy), 32'h0);
      end
      handshakeAndGap("rnd");
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      y           = '0;
      y_valid     = 1'b0;
      num_samples = '0;
      sig_ready   = 1'b0;
`ifdef Y_COMPACT_CMP_EN
      golden_sig  = 32'h0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset_sig", sig, REF_SEED);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_valid", 32'(sig_valid), 32'h0);
`ifdef Y_COMPACT_CMP_EN
      checkOutput("reset_pass", 32'(pass), 32'h0);
      checkOutput("reset_fail", 32'(fail), 32'h0);
`endif
      rst = 1'b0;
      applyStimulus(1'b0, 16'd0, 245'h0, 1'b1, 1'b1);
      checkOutput("idle_ignores_yvalid", sig, REF_SEED);

      $display("[TB] single-sample runs");
      runSingle("zero", 245'h0, 32'hFB3EE249);
      handshakeAndGap("zero");
      runSingle("bit0", 245'h1, 32'hFB3EE248);
      handshakeAndGap("bit0");
      runSingle("bit244", {1'b1, 244'h0}, 32'hFB2EE249);
      handshakeAndGap("bit244");

      $display("[TB] zero-length run");
      applyStimulus(1'b1, 16'd0, 245'h0, 1'b0, 1'b0);
      modelSig = REF_SEED;
      checkOutput("n0_valid", 32'(sig_valid), 32'h1);
      checkOutput("n0_busy", 32'(busy), 32'h0);
      checkOutput("n0_sig", sig, 32'hFFFFFFFF);
      handshakeAndGap("n0");

      $display("[TB] random runs with gaps and held results");
      runRandom(16'd3, 5);
      for (int r = 0; r < 6; r++) begin
         runRandom(16'($urandom_range(1, 8)), $urandom_range(0, 3));
      end

      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 16'd4, 245'h0, 1'b0, 1'b0);
      modelSig = REF_SEED;
      for (int k = 0; k < 2; k++) begin
         y = randY();
         applyStimulus(1'b0, 16'd0, y, 1'b1, 1'b0);
         modelSig = refStep(modelSig, y);
      end
      checkOutput("midrun_sig", sig, modelSig);
      checkOutput("midrun_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("abort_sig", sig, REF_SEED);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_valid", 32'(sig_valid), 32'h0);
      applyStimulus(1'b0, 16'd0, 245'h0, 1'b1, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'd0, 245'h0, 1'b0, 1'b0);
      checkOutput("after_abort_valid", 32'(sig_valid), 32'h0);
      runSingle("post_abort", 245'h0, 32'hFB3EE249);

`ifdef Y_COMPACT_CMP_EN
      $display("[TB] golden compare");
      golden_sig = 32'hFB3EE249;
      #1;
      checkOutput("cmp_pass", 32'(pass), 32'h1);
      checkOutput("cmp_fail", 32'(fail), 32'h0);
      handshakeAndGap("cmp");
      checkOutput("cmp_idle_pass", 32'(pass), 32'h0);
      golden_sig = 32'h0;
      runSingle("cmp_bad", 245'h0, 32'hFB3EE249);
      checkOutput("cmp_bad_pass", 32'(pass), 32'h0);
      checkOutput("cmp_bad_fail", 32'(fail), 32'h1);
      handshakeAndGap("cmp_bad");
      checkOutput("cmp_idle_fail", 32'(fail), 32'h0);
`else
      handshakeAndGap("post_abort");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
